// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: N_REQ valid/ready producers share one FIFO write port,
// one producer per burst of up to MAX_BURST beats, throttled by full/almost_full.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]         fifo_din,
  output logic                     fifo_wr_en,
  input  logic                     fifo_full,
  input  logic                     fifo_almost_full,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]    r_state;
  logic [GW-1:0] r_grant_id;
  logic [GW-1:0] r_last;
  logic [CW-1:0] r_beat_cnt;

  logic          w_busy;
  logic          w_sel_valid;
  logic          w_wr_en;
  logic          w_found;
  logic [GW-1:0] w_pick;
  logic [GW-1:0] w_cand;
  logic [WIDTH-1:0] w_slice;

  // Scan last+1, last+2, ... so the producer after the previous owner wins first.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = GW'((int'(r_last) + k) % N_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_slice = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant_id == GW'(i)) w_slice = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign w_busy      = (r_state == S_BURST);
  assign w_sel_valid = req_valid[r_grant_id];
  assign w_wr_en     = w_busy && w_sel_valid && !fifo_full;

  always_comb begin
    req_ready = '0;
    if (w_busy && !fifo_full) req_ready[r_grant_id] = 1'b1;
  end

  // Data is forced to zero outside a burst so the port is never X and is 0 under reset.
  assign fifo_din   = w_busy ? w_slice : '0;
  assign fifo_wr_en = w_wr_en;
  assign grant_id   = r_grant_id;
  assign busy       = w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
      r_last     <= GW'(N_REQ - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found && !fifo_almost_full) begin
            r_grant_id <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_wr_en) begin
            if (r_beat_cnt == CW'(MAX_BURST - 1)) begin
              r_beat_cnt <= '0;
              r_last     <= r_grant_id;
              r_state    <= S_IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end else if (!w_sel_valid) begin
            // Producer ran dry: give up the port early.
            r_last  <= r_grant_id;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus a randomized run against a
// transaction-level arbitration model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic [W-1:0]  fifo_din;
  logic          fifo_wr_en;
  logic          fifo_full;
  logic          fifo_almost_full;
  logic [1:0]    grant_id;
  logic          busy;

  int total = 0;
  int bad   = 0;

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic set_data(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  // Leaves the bench at a falling edge with reset released and inputs idle.
  task automatic apply_reset();
    rst_n = 1'b0; req_valid = '0; req_data = '0;
    fifo_full = 1'b0; fifo_almost_full = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; req_data = 32'h12345678;
    fifo_full = 1'b0; fifo_almost_full = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_ready got=%h exp=0", req_ready); end
    total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b exp=0", fifo_wr_en); end
    total++; if (fifo_din !== 8'h00) begin bad++; $display("FAIL reset_din got=%h exp=00", fifo_din); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
  endtask

  task automatic test_single();
    logic [9:0] ew, eb;
    int k;
    ew = 10'b0011011110;
    eb = 10'b0111011110;
    k = 0;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      req_valid = (k < 6) ? 4'b0100 : 4'b0000;
      set_data(2, 8'hA0 + 8'(k));
      #1;
      total++; if (fifo_wr_en !== ew[c]) begin bad++; $display("FAIL single_wr c=%0d got=%b exp=%b", c, fifo_wr_en, ew[c]); end
      total++; if (busy !== eb[c]) begin bad++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy, eb[c]); end
      if (ew[c]) begin
        total++; if (fifo_din !== 8'hA0 + 8'(k)) begin bad++; $display("FAIL single_din c=%0d got=%h exp=%h", c, fifo_din, 8'hA0 + 8'(k)); end
        total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL single_gid c=%0d got=%0d exp=2", c, grant_id); end
      end
      if (!eb[c]) begin
        total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL single_ready c=%0d got=%h exp=0", c, req_ready); end
      end
      if (req_valid[2] && req_ready[2]) k++;
      @(negedge clk);
    end
    total++; if (k !== 6) begin bad++; $display("FAIL single_count got=%0d exp=6", k); end
  endtask

  task automatic test_fair();
    int cnt[N];
    int exp_g;
    logic exp_wr;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    apply_reset();
    req_valid = 4'hF;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < N; i++) set_data(i, {2'(i), 6'(cnt[i])});
      #1;
      exp_wr = (c % 5) != 0;
      exp_g  = (c / 5) % 4;
      total++; if (fifo_wr_en !== exp_wr) begin bad++; $display("FAIL fair_wr c=%0d got=%b exp=%b", c, fifo_wr_en, exp_wr); end
      if (exp_wr) begin
        total++; if (grant_id !== 2'(exp_g)) begin bad++; $display("FAIL fair_gid c=%0d got=%0d exp=%0d", c, grant_id, exp_g); end
        total++; if (fifo_din !== {2'(exp_g), 6'(cnt[exp_g])}) begin bad++; $display("FAIL fair_din c=%0d got=%h exp=%h", c, fifo_din, {2'(exp_g), 6'(cnt[exp_g])}); end
      end
      for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) cnt[i]++;
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) begin
      total++; if (cnt[i] !== 4) begin bad++; $display("FAIL fair_beats p=%0d got=%0d exp=4", i, cnt[i]); end
    end
  endtask

  task automatic test_stall();
    logic [8:0] ew;
    int k;
    ew = 9'b011000110;
    k = 0;
    apply_reset();
    req_valid = 4'b0010;
    for (int c = 0; c < 9; c++) begin
      fifo_full = (c >= 3 && c <= 5);
      set_data(1, 8'hB0 + 8'(k));
      #1;
      total++; if (fifo_wr_en !== ew[c]) begin bad++; $display("FAIL stall_wr c=%0d got=%b exp=%b", c, fifo_wr_en, ew[c]); end
      if (fifo_full) begin
        total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL stall_ready c=%0d got=%h exp=0", c, req_ready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy c=%0d got=%b exp=1", c, busy); end
      end
      if (ew[c]) begin
        total++; if (fifo_din !== 8'hB0 + 8'(k)) begin bad++; $display("FAIL stall_din c=%0d got=%h exp=%h", c, fifo_din, 8'hB0 + 8'(k)); end
      end
      if (req_valid[1] && req_ready[1]) k++;
      @(negedge clk);
    end
    fifo_full = 1'b0;
    total++; if (k !== 4) begin bad++; $display("FAIL stall_count got=%0d exp=4", k); end
  endtask

  task automatic test_early();
    apply_reset();
    req_valid = 4'b1001; set_data(0, 8'hC0); set_data(3, 8'hD0);
    @(negedge clk); #1;
    total++; if (fifo_wr_en !== 1'b1 || grant_id !== 2'd0) begin bad++; $display("FAIL early_first got=wr%b/g%0d exp=wr1/g0", fifo_wr_en, grant_id); end
    total++; if (fifo_din !== 8'hC0) begin bad++; $display("FAIL early_din got=%h exp=c0", fifo_din); end
    @(negedge clk); req_valid = 4'b1000; #1;
    total++; if (busy !== 1'b1 || fifo_wr_en !== 1'b0) begin bad++; $display("FAIL early_end got=busy%b/wr%b exp=busy1/wr0", busy, fifo_wr_en); end
    @(negedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL early_bubble got=%b exp=0", busy); end
    @(negedge clk); #1;
    total++; if (grant_id !== 2'd3 || fifo_wr_en !== 1'b1) begin bad++; $display("FAIL early_next got=g%0d/wr%b exp=g3/wr1", grant_id, fifo_wr_en); end
    total++; if (fifo_din !== 8'hD0) begin bad++; $display("FAIL early_din3 got=%h exp=d0", fifo_din); end
    req_valid = '0;
  endtask

  task automatic test_afull();
    apply_reset();
    fifo_almost_full = 1'b1; req_valid = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (busy !== 1'b0 || req_ready !== 4'h0 || fifo_wr_en !== 1'b0) begin bad++; $display("FAIL afull_hold c=%0d got=busy%b/rdy%h/wr%b exp=0/0/0", c, busy, req_ready, fifo_wr_en); end
      @(negedge clk);
    end
    fifo_almost_full = 1'b0; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL afull_drop got=%b exp=0", busy); end
    @(negedge clk); #1;
    total++; if (busy !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001) begin bad++; $display("FAIL afull_grant got=busy%b/g%0d/rdy%h exp=1/0/1", busy, grant_id, req_ready); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_valid = 4'b1000;
    for (int c = 0; c < 3; c++) begin set_data(3, 8'hE0 + 8'(c)); @(negedge clk); end
    set_data(3, 8'hE2); #1;
    total++; if (busy !== 1'b1 || fifo_wr_en !== 1'b1 || grant_id !== 2'd3) begin bad++; $display("FAIL mid_pre got=busy%b/wr%b/g%0d exp=1/1/3", busy, fifo_wr_en, grant_id); end
    rst_n = 1'b0; #1;
    total++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'h0 || busy !== 1'b0 || grant_id !== 2'd0) begin bad++; $display("FAIL mid_reset got=wr%b/rdy%h/busy%b/g%0d exp=0/0/0/0", fifo_wr_en, req_ready, busy, grant_id); end
    @(negedge clk); rst_n = 1'b1; req_valid = 4'b1001; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_idle got=%b exp=0", busy); end
    @(negedge clk); #1;
    total++; if (busy !== 1'b1 || grant_id !== 2'd0) begin bad++; $display("FAIL mid_regrant got=busy%b/g%0d exp=1/0", busy, grant_id); end
    req_valid = '0;
  endtask

  // Model: a grant is "owner + beats remaining"; arbitration searches owners after the last one.
  task automatic test_random();
    logic m_busy; int m_gid, m_last, m_left;
    logic [N-1:0] e_rdy; logic e_wr; logic [W-1:0] e_din; int cand;
    apply_reset();
    m_busy = 1'b0; m_gid = 0; m_last = N - 1; m_left = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 9) < 7);
        set_data(i, 8'($urandom));
      end
      fifo_full        = ($urandom_range(0, 99) < 15);
      fifo_almost_full = ($urandom_range(0, 99) < 25);
      #1;
      e_rdy = (m_busy && !fifo_full) ? 4'(1 << m_gid) : 4'h0;
      e_wr  = m_busy && req_valid[m_gid] && !fifo_full;
      e_din = req_data[m_gid*W +: W];
      total++; if (req_ready !== e_rdy) begin bad++; $display("FAIL rnd_ready c=%0d got=%h exp=%h", c, req_ready, e_rdy); end
      total++; if (fifo_wr_en !== e_wr) begin bad++; $display("FAIL rnd_wr c=%0d got=%b exp=%b", c, fifo_wr_en, e_wr); end
      total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, m_busy); end
      total++; if (grant_id !== 2'(m_gid)) begin bad++; $display("FAIL rnd_gid c=%0d got=%0d exp=%0d", c, grant_id, m_gid); end
      if (m_busy) begin
        total++; if (fifo_din !== e_din) begin bad++; $display("FAIL rnd_din c=%0d got=%h exp=%h", c, fifo_din, e_din); end
      end
      if (!m_busy) begin
        if (req_valid != 0 && !fifo_almost_full) begin
          for (int k = N; k >= 1; k--) begin
            cand = (m_last + k) % N;
            if (req_valid[cand]) m_gid = cand;
          end
          m_busy = 1'b1; m_left = MB;
        end
      end else if (e_wr) begin
        m_left--;
        if (m_left == 0) begin m_last = m_gid; m_busy = 1'b0; end
      end else if (!req_valid[m_gid]) begin
        m_last = m_gid; m_busy = 1'b0;
      end
      @(negedge clk);
    end
    fifo_full = 1'b0; fifo_almost_full = 1'b0; req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fair();
    test_stall();
    test_early();
    test_afull();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
